// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and constants for the frame loader and display path
//
// Contents:
//   frame_state_t  : loader FSM states
//   RGB565 field   : bit positions used when the display slices a pixel word
//   DEFAULT_*      : default picture geometry and stall timeout
//   width_of()     : counter width for a value range, never below 1 bit
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_HI = 3'd1,
    GET_LO = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } frame_state_t;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  localparam int DEFAULT_L       = 640;
  localparam int DEFAULT_W       = 480;
  localparam int DEFAULT_TIMEOUT = 25_175_000;

  // Bits needed to count 0..n-1; a 1-entry range still gets one bit so
  // that no zero-width vector is ever declared.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// rtl/stall_timer.sv - idle-cycle counter with clear, enable and terminal-count pulse
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   zero the count (wins over en)
//   en   in   count one cycle
//   tc   out  high in the cycle whose increment takes the count to TIMEOUT-1
//
// tc is combinational so the owner can register its abort in the same edge
// that the count lands on TIMEOUT-1; the abort then becomes visible exactly
// TIMEOUT cycles after the last clear. TIMEOUT must be at least 2.
module stall_timer
  import frame_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = width_of(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = en && !clr && (count == CW'(TIMEOUT - 2));

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - packs a byte stream into RGB565 words and writes them to frame RAM
//
// Ports:
//   clk_vga   in   pixel/system clock
//   rst       in   synchronous active-high reset
//   start     in   one-cycle pulse, begin loading a frame (ignored unless idle)
//   in_valid  in   byte available
//   in_data   in   byte, high byte of each pixel first
//   in_ready  out  byte accepted this cycle when in_valid is high
//   wr_en     out  RAM write strobe
//   wr_addr   out  RAM write address, raster order 0 .. L*W-1
//   wr_data   out  RGB565 pixel
//   busy      out  frame load in progress
//   done      out  one-cycle pulse after the last pixel write
//   err       out  one-cycle pulse on stall timeout abort
module frame_loader
  import frame_pkg::*;
#(
  parameter int L       = DEFAULT_L,
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = $clog2(L * W)
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int COL_W = width_of(L);
  localparam int ROW_W = width_of(W);

  frame_state_t state, state_nx;

  logic [7:0]        hi;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;

  logic accept;
  logic xfer;
  logic launch;
  logic last_pix;
  logic stall_tc;

  // in_ready depends only on the state register, never on in_valid.
  assign accept   = (state == GET_HI) || (state == GET_LO);
  assign in_ready = accept;
  assign xfer     = in_valid && accept;
  assign launch   = (state == IDLE) && start;
  assign last_pix = (col == COL_W'(L - 1)) && (row == ROW_W'(W - 1));

  stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk (clk_vga),
    .rst (rst),
    .clr (launch || xfer),
    .en  (accept),
    .tc  (stall_tc)
  );

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = GET_HI;
        end
      end
      GET_HI: begin
        if (xfer) begin
          state_nx = GET_LO;
        end else if (stall_tc) begin
          state_nx = IDLE;
        end
      end
      GET_LO: begin
        if (xfer) begin
          state_nx = WRITE;
        end else if (stall_tc) begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        wr_en    = 1'b1;
        state_nx = last_pix ? DONE : GET_HI;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // addr tracks the next pixel to be written; wr_addr is loaded from it when
  // the low byte arrives, so wr_addr only changes on entry to WRITE and
  // holds otherwise. addr/col/row stop at the last pixel instead of wrapping.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hi      <= '0;
      col     <= '0;
      row     <= '0;
      addr    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      // stall_tc already excludes cycles with a transfer, so a byte
      // arriving on the terminal cycle cancels the abort.
      err <= stall_tc;
      case (state)
        IDLE: begin
          if (start) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
          end
        end
        GET_HI: begin
          if (xfer) begin
            hi <= in_data;
          end
        end
        GET_LO: begin
          if (xfer) begin
            wr_data <= {hi, in_data};
            wr_addr <= addr;
          end
        end
        WRITE: begin
          if (!last_pix) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_W'(L - 1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader (L=4, W=2, TIMEOUT=10)
module tb_frame_loader;

  localparam int TL = 4;
  localparam int TW = 2;
  localparam int TT = 10;
  localparam int AW = $clog2(TL * TW);

  logic          clk_vga = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;

  frame_loader #(
    .L       (TL),
    .W       (TW),
    .TIMEOUT (TT)
  ) dut (
    .clk_vga  (clk_vga),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int last_xfer_cyc = 0;
  int start_cyc = 0;
  logic [AW-1:0] wq_addr[$];
  logic [15:0]   wq_data[$];

  always @(posedge clk_vga) cyc <= cyc + 1;

  always @(negedge clk_vga) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic begin_frame(input logic valid0);
    start     = 1'b1;
    in_valid  = valid0;
    in_data   = 8'h00;
    start_cyc = cyc;
  endtask

  // Source model: bytes 0,1,2,... each held until accepted.
  task automatic feed(input bit toggle, input int nbytes, input int restart_at, input string tag);
    int  idx = 0;
    int  n = 0;
    bit  took;
    while (idx < nbytes && n < 200) begin
      took = in_valid && in_ready;
      if (took) last_xfer_cyc = cyc;
      step();
      n++;
      start = (n == restart_at);
      if (took) idx++;
      in_data = 8'(idx);
      in_valid = toggle ? ~in_valid : 1'b1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check({tag, "_bytes_fed"}, idx, nbytes);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
  endtask

  task automatic check_writes(input int nexp, input string tag);
    logic [15:0] exp_d;
    check({tag, "_nwrites"}, wq_addr.size(), nexp);
    for (int k = 0; k < nexp && k < wq_addr.size(); k++) begin
      exp_d = {8'(2 * k), 8'(2 * k + 1)};
      check($sformatf("%s_addr%0d", tag, k), 32'(wq_addr[k]), k);
      check($sformatf("%s_data%0d", tag, k), 32'(wq_data[k]), 32'(exp_d));
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Idle: valid bytes without start are never accepted
    clear_log();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_in_ready%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    step();
    check("idle_nwrites", wq_addr.size(), 0);

    // Full frame, in_valid held high
    clear_log();
    begin_frame(1'b1);
    feed(1'b0, 16, -1, "full");
    wait_done("full");
    check_writes(8, "full");
    check("full_done_cnt", done_cnt, 1);
    check("full_done_latency", done_cyc - start_cyc, 25);
    check("full_busy_after", busy, 0);
    check("full_err_cnt", err_cnt, 0);
    check("full_addr_hold", wr_addr, 7);
    step();
    step();
    check("full_addr_hold2", wr_addr, 7);

    // Second start while busy is ignored
    clear_log();
    begin_frame(1'b1);
    feed(1'b0, 16, 10, "rest");
    wait_done("rest");
    check_writes(8, "rest");
    check("rest_done_cnt", done_cnt, 1);

    // Stalled stream, new start after done restarts at addr 0
    clear_log();
    begin_frame(1'b1);
    feed(1'b1, 16, -1, "stall");
    wait_done("stall");
    check_writes(8, "stall");
    check("stall_done_cnt", done_cnt, 1);

    // Timeout after 3 bytes
    clear_log();
    begin_frame(1'b1);
    feed(1'b0, 3, -1, "tmo");
    for (int i = 0; i < 30 && err_cnt == 0; i++) step();
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_err_latency", err_cyc - last_xfer_cyc, 10);
    check_writes(1, "tmo");
    check("tmo_busy", busy, 0);
    check("tmo_in_ready", in_ready, 0);
    repeat (5) step();
    check("tmo_err_once", err_cnt, 1);
    check("tmo_no_done", done_cnt, 0);

    // Reset mid-frame while writing addr 5
    clear_log();
    begin_frame(1'b1);
    feed(1'b0, 12, -1, "mrst");
    check("mrst_wr_en_pre", wr_en, 1);
    check("mrst_wr_addr_pre", wr_addr, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_wr_en_post", wr_en, 0);
    check("mrst_busy_post", busy, 0);
    in_valid = 1'b1;
    repeat (15) step();
    in_valid = 1'b0;
    check_writes(6, "mrst");
    check("mrst_no_done", done_cnt, 0);
    check("mrst_no_err", err_cnt, 0);

    clear_log();
    begin_frame(1'b1);
    feed(1'b0, 16, -1, "after");
    wait_done("after");
    check_writes(8, "after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
